// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [1:0] REQ_IFETCH = 2'd0;
    localparam logic [1:0] REQ_DREAD  = 2'd1;
    localparam logic [1:0] REQ_DWRITE = 2'd2;

    localparam int unsigned TID_W_DEFAULT = 2;
    typedef logic [TID_W_DEFAULT-1:0] tid_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signals of the shared RAM port arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned TID_W = 2
);
    logic [2:0]       ReqValid;
    logic [31:0]      IfAddress;
    logic [31:0]      DcReadAddress;
    logic [31:0]      DcWriteAddress;
    logic [31:0]      DcWriteData;
    logic [TID_W-1:0] IfTID;
    logic [TID_W-1:0] DcReadTID;
    logic [TID_W-1:0] DcWriteTID;
    logic [2:0]       ReqAck;
    logic [31:0]      RespData;
    logic             RespError;
    logic             DoneValid;
    logic [TID_W-1:0] DoneForTID;
    logic             Busy;
    logic             RamRead;
    logic             RamWrite;
    logic [31:0]      RamReadAddress;
    logic [31:0]      RamWriteAddress;
    logic [31:0]      RamWriteData;
    logic [31:0]      RamData;
    logic             DoneReadingData;
    logic             DoneWritingData;

    modport slave (
        input  ReqValid, IfAddress, DcReadAddress, DcWriteAddress, DcWriteData,
        input  IfTID, DcReadTID, DcWriteTID, RamData, DoneReadingData, DoneWritingData,
        output ReqAck, RespData, RespError, DoneValid, DoneForTID, Busy,
        output RamRead, RamWrite, RamReadAddress, RamWriteAddress, RamWriteData
    );

    modport master (
        output ReqValid, IfAddress, DcReadAddress, DcWriteAddress, DcWriteData,
        output IfTID, DcReadTID, DcWriteTID, RamData, DoneReadingData, DoneWritingData,
        input  ReqAck, RespData, RespError, DoneValid, DoneForTID, Busy,
        input  RamRead, RamWrite, RamReadAddress, RamWriteAddress, RamWriteData
    );
endinterface

// File: rtl/rr_pick3.sv
// Three-way round-robin picker with a forced store-first override.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last,
    input  logic       override,
    output logic [2:0] grant,
    output logic [1:0] idx
);
    logic [1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        // Scan lowest priority first so the highest-priority hit is written last.
        for (int k = 2; k >= 0; k--) begin
            cand = 2'((int'(last) + 1 + k) % 3);
            if (req[cand]) begin
                grant = 3'b001 << cand;
                idx   = cand;
            end
        end
        if (override) begin
            grant = 3'b100;
            idx   = REQ_DWRITE;
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Single-outstanding scheduler of ifetch refill, dcache refill and dcache store onto one
// RAM port; completions carry the requester's hart ID and a timeout error flag.
module ram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TID_W          = 2
) (
    input logic              clk,
    input logic              Reset,
    ram_port_arbiter_if.slave bus
);
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [1:0]       lastPtr;
    logic [2:0]       winGrant;
    logic [TID_W-1:0] winTid;
    logic [CntW-1:0]  count;
    logic [2:0]       pickGrant;
    logic [1:0]       pickIdx;
    logic             storeFirst;

    // A refill must not overtake a pending store to the same word.
    assign storeFirst = bus.ReqValid[REQ_DREAD] & bus.ReqValid[REQ_DWRITE] &
                        (bus.DcReadAddress[31:2] == bus.DcWriteAddress[31:2]);

    rr_pick3 u_pick (
        .req      (bus.ReqValid),
        .last     (lastPtr),
        .override (storeFirst),
        .grant    (pickGrant),
        .idx      (pickIdx)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state               <= IDLE;
            lastPtr             <= REQ_DWRITE;
            winGrant            <= '0;
            winTid              <= '0;
            count               <= '0;
            bus.ReqAck          <= '0;
            bus.RespData        <= '0;
            bus.RespError       <= 1'b0;
            bus.DoneValid       <= 1'b0;
            bus.DoneForTID      <= '0;
            bus.Busy            <= 1'b0;
            bus.RamRead         <= 1'b0;
            bus.RamWrite        <= 1'b0;
            bus.RamReadAddress  <= '0;
            bus.RamWriteAddress <= '0;
            bus.RamWriteData    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.ReqValid) begin
                        lastPtr  <= pickIdx;
                        winGrant <= pickGrant;
                        count    <= '0;
                        bus.Busy <= 1'b1;
                        case (pickIdx)
                            REQ_IFETCH: begin
                                bus.RamReadAddress <= bus.IfAddress;
                                winTid             <= bus.IfTID;
                                bus.RamRead        <= 1'b1;
                                state              <= READ;
                            end
                            REQ_DREAD: begin
                                bus.RamReadAddress <= bus.DcReadAddress;
                                winTid             <= bus.DcReadTID;
                                bus.RamRead        <= 1'b1;
                                state              <= READ;
                            end
                            default: begin
                                bus.RamWriteAddress <= bus.DcWriteAddress;
                                bus.RamWriteData    <= bus.DcWriteData;
                                winTid              <= bus.DcWriteTID;
                                bus.RamWrite        <= 1'b1;
                                state               <= WRITE;
                            end
                        endcase
                    end
                end
                READ: begin
                    if (bus.DoneReadingData || count == CntLast) begin
                        bus.RespData   <= bus.DoneReadingData ? bus.RamData : '0;
                        bus.RespError  <= !bus.DoneReadingData;
                        bus.RamRead    <= 1'b0;
                        bus.ReqAck     <= winGrant;
                        bus.DoneValid  <= 1'b1;
                        bus.DoneForTID <= winTid;
                        state          <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.DoneWritingData || count == CntLast) begin
                        bus.RespData   <= '0;
                        bus.RespError  <= !bus.DoneWritingData;
                        bus.RamWrite   <= 1'b0;
                        bus.ReqAck     <= winGrant;
                        bus.DoneValid  <= 1'b1;
                        bus.DoneForTID <= winTid;
                        state          <= RESP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RESP: begin
                    bus.ReqAck    <= '0;
                    bus.DoneValid <= 1'b0;
                    bus.RespError <= 1'b0;
                    bus.Busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
